// File: rtl/keypad_pkg.sv
// Shared keypad geometry and key-vector helpers for the password-lock front end.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;
  localparam logic [KP_KEYS-1:0] KP_NONE = '0;

  // True when at most one key bit is set (clearing the lowest set bit leaves zero).
  function automatic logic at_most_one(input logic [KP_KEYS-1:0] v);
    return (v & (v - KP_KEYS'(1))) == '0;
  endfunction

  function automatic logic [3:0] key_index(input logic [KP_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KP_KEYS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Width-parameterised two-flop synchroniser; resets to all ones (idle pulled-up lines).
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sampling, frame-level debounce and one-hot key output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_COLS-1:0] col_n,
  output logic [KP_ROWS-1:0] row_n,
  output logic [KP_KEYS-1:0] onehot,
  output logic               key_press,
  output logic [3:0]         key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [KP_COLS-1:0] col_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         row_sel;
  logic [1:0]         next_row;
  logic [KP_KEYS-1:0] map;
  logic               frame_done;
  logic [KP_KEYS-1:0] cand;
  logic [KP_KEYS-1:0] prev_cand;
  logic [CNT_W-1:0]   stable_cnt;
  logic [CNT_W-1:0]   stable_next;

  sync2 #(.WIDTH(KP_COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_sync)
  );

  assign next_row = row_sel + 2'd1;

  // Multi-key frames are treated as "no key" so ghosting can never reach onehot.
  always_comb begin
    cand        = at_most_one(map) ? map : KP_NONE;
    stable_next = '0;
    if (cand == prev_cand) begin
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      row_sel    <= '0;
      row_n      <= ~KP_ROWS'(1);
      map        <= KP_NONE;
      frame_done <= 1'b0;
      prev_cand  <= KP_NONE;
      stable_cnt <= '0;
      onehot     <= KP_NONE;
      key_press  <= 1'b0;
      key_code   <= '0;
    end else begin
      key_press  <= 1'b0;
      frame_done <= 1'b0;

      // Columns are sampled at the end of each row's dwell so the lines have settled.
      if (div_cnt == DIV_LAST) begin
        div_cnt                      <= '0;
        map[{row_sel, 2'b00} +: KP_COLS] <= ~col_sync;
        row_sel                      <= next_row;
        row_n                        <= ~(KP_ROWS'(1) << next_row);
        frame_done                   <= (row_sel == 2'(KP_ROWS - 1));
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (frame_done) begin
        prev_cand  <= cand;
        stable_cnt <= stable_next;
        if (stable_next == STABLE_MAX && cand != onehot) begin
          onehot    <= cand;
          key_press <= (cand != KP_NONE);
          if (cand != KP_NONE) key_code <= key_index(cand);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad contact model, vector table, press scoreboard, corner sequences.
module tb_keypad_scanner;

  localparam int SD     = 4;
  localparam int DS     = 3;
  localparam int FRAME  = 4 * SD;
  localparam int BUDGET = 4 * FRAME + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] onehot;
  logic        key_press;
  logic [3:0]  key_code;

  logic [15:0] pressed;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] onehot;
    logic [3:0]  code;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_onehot;
    logic [3:0]  exp_code;
    bit          press;
  } vec_t;
  vec_t tbl[8];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .onehot    (onehot),
    .key_press (key_press),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed contact pulls its column low while its row is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0) begin
      check("onehot_at_most_one_bit", 32'($countones(onehot) <= 1), 32'd1);
      if (key_press === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_key_press: onehot=%h key_code=%0d, none expected", onehot, key_code);
        end else begin
          e = exp_q.pop_front();
          check("press_onehot", 32'(onehot), 32'(e.onehot));
          check("press_key_code", 32'(key_code), 32'(e.code));
        end
      end
    end
  end

  task automatic apply(input int id, input vec_t v);
    int t;
    pressed = v.keys;
    if (v.press) exp_q.push_back('{v.exp_onehot, v.exp_code});
    t = 0;
    while (onehot !== v.exp_onehot && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("vec%0d_onehot", id), 32'(onehot), 32'(v.exp_onehot));
    if (v.press) check($sformatf("vec%0d_key_code", id), 32'(key_code), 32'(v.exp_code));
    repeat (5 * FRAME) @(negedge clk);
    check($sformatf("vec%0d_onehot_held", id), 32'(onehot), 32'(v.exp_onehot));
    check($sformatf("vec%0d_pending_presses", id), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vec_t v;
    tbl[0] = '{16'h0040, 16'h0040, 4'd6,  1'b1};
    tbl[1] = '{16'h0000, 16'h0000, 4'd0,  1'b0};
    tbl[2] = '{16'h8001, 16'h0000, 4'd0,  1'b0};
    tbl[3] = '{16'h0001, 16'h0001, 4'd0,  1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 4'd0,  1'b0};
    tbl[5] = '{16'h2000, 16'h2000, 4'd13, 1'b1};
    tbl[6] = '{16'h0800, 16'h0800, 4'd11, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 4'd0,  1'b0};

    pressed = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_row_n", 32'(row_n), 32'h0000_000E);
    check("reset_onehot", 32'(onehot), 32'd0);
    check("reset_key_press", 32'(key_press), 32'd0);
    check("reset_key_code", 32'(key_code), 32'd0);
    rst = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("scan_row0", 32'(row_n), 32'hE);
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] pat;
      pat = ~(4'b0001 << (i % 4));
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("scan_step%0d", i), 32'(row_n), 32'(pat));
    end

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      apply(i, v);
    end

    // Bounce on row2/col0: contact toggles every 10 cycles for 40 cycles, then opens.
    seen = 1'b0;
    pressed = 16'h0100;
    for (int i = 0; i < 40 + 5 * FRAME; i++) begin
      if (i < 40 && i % 10 == 0 && i != 0) pressed = pressed ^ 16'h0100;
      if (i == 40) pressed = '0;
      @(negedge clk);
      if (onehot !== 16'h0000) seen = 1'b1;
    end
    check("bounce_onehot_stays_zero", 32'(seen), 32'd0);
    check("bounce_pending_presses", 32'(exp_q.size()), 32'd0);

    v = '{16'h0100, 16'h0100, 4'd8, 1'b1};
    apply(8, v);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_onehot", 32'(onehot), 32'd0);
    check("midreset_row_n", 32'(row_n), 32'hE);
    check("midreset_key_press", 32'(key_press), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v = '{16'h0100, 16'h0100, 4'd8, 1'b1};
    apply(9, v);

    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("final_pending_presses", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
